// File: rtl/ra_64x72_bist_pkg.sv
// ---------------------------------------------------------------------------
// ra_64x72_bist_pkg
// Shared definitions for the 64x72 array BIST / port-mux stage:
//   - march state encoding
//   - array geometry (address count, data width) and inter-phase gap length
//   - background-word helper used by both the write and the expect paths
// ---------------------------------------------------------------------------
package ra_64x72_bist_pkg;

    localparam int BIST_NADR = 64;   // addresses swept per phase
    localparam int BIST_GAP  = 1;    // idle cycles between phases
    localparam int BIST_AW   = 6;    // address width
    localparam int BIST_DW   = 72;   // data width

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_W0    = 4'd1,
        ST_G0    = 4'd2,
        ST_R0    = 4'd3,
        ST_G1    = 4'd4,
        ST_W1    = 4'd5,
        ST_G2    = 4'd6,
        ST_R1    = 4'd7,
        ST_DRAIN = 4'd8
    } bist_state_e;

    // Odd addresses hold the inverted background so that adjacent words
    // always differ in every bit.
    function automatic logic [BIST_DW-1:0] bg_word(input logic [BIST_AW-1:0] adr,
                                                    input logic [BIST_DW-1:0] pat);
        return adr[0] ? ~pat : pat;
    endfunction

endpackage

// File: rtl/ra_64x72_bist_cmp.sv
// ---------------------------------------------------------------------------
// ra_bist_cmp
// Read-data checker for one array read port. Each issued read pushes its
// valid, address and expected word into an RD_LAT-deep shift register; the
// oldest stage lines up with the data the array returns and is compared.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears valids)
//   iss_vld_i       a read is being issued to the array this cycle
//   iss_adr_i       address of that read
//   iss_exp_i       word the read is expected to return
//   rd_dat_i        data returned by the array port
//   mis_o           returned data differs from expectation (valid compare)
//   mis_adr_o       address belonging to the compare on mis_o
// ---------------------------------------------------------------------------
module ra_bist_cmp #(
    parameter int RD_LAT = 2,
    parameter int DW     = 72,
    parameter int AW     = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iss_vld_i,
    input  logic [AW-1:0] iss_adr_i,
    input  logic [DW-1:0] iss_exp_i,
    input  logic [DW-1:0] rd_dat_i,
    output logic          mis_o,
    output logic [AW-1:0] mis_adr_o
);

    logic          vld_q [RD_LAT];
    logic          vld_d [RD_LAT];
    logic [AW-1:0] adr_q [RD_LAT];
    logic [AW-1:0] adr_d [RD_LAT];
    logic [DW-1:0] exp_q [RD_LAT];
    logic [DW-1:0] exp_d [RD_LAT];

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign vld_d[gi] = iss_vld_i;
            assign adr_d[gi] = iss_adr_i;
            assign exp_d[gi] = iss_exp_i;
        end else begin : g_tail
            assign vld_d[gi] = vld_q[gi-1];
            assign adr_d[gi] = adr_q[gi-1];
            assign exp_d[gi] = exp_q[gi-1];
        end
    end

    // Only the valid bits need a reset; address/expected words are
    // qualified by them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RD_LAT; i++) begin
            if (reset) begin
                vld_q[i] <= 1'b0;
            end else begin
                vld_q[i] <= vld_d[i];
            end
            adr_q[i] <= adr_d[i];
            exp_q[i] <= exp_d[i];
        end
    end

    assign mis_o     = vld_q[RD_LAT-1] && (rd_dat_i != exp_q[RD_LAT-1]);
    assign mis_adr_o = adr_q[RD_LAT-1];

endmodule

// File: rtl/ra_64x72_bist.sv
// ---------------------------------------------------------------------------
// ra_64x72_bist
// BIST engine and port mux in front of the 64x72 2R/1W array wrapper.
// Idle: functional sys_* requests pass combinationally to ra_*.
// Running: a four-sweep march (W0, R0, W1, R1 with one-cycle gaps and a
// RD_LAT-cycle drain) owns all three array ports; both read ports are
// checked against the expected background word.
//
// Parameters: RD_LAT (array read latency), PATTERN (background word).
// Ports:
//   clk, reset                         clock, sync active-high reset
//   start                              one-cycle run request (idle only)
//   busy / done / fail                 run status (done and fail sticky)
//   fail_adr / fail_port / fail_cnt    first-miscompare capture and count
//   sys_rd_*_0/1, sys_wr_*_0           functional requests
//   ra_rd_*_0/1, ra_wr_*_0             array ports
//   ra_rd_dat_0/1                      array read data
// Build option: define TOYSRAM_BIST_DIAG_EN to keep the fail_adr/fail_port/
// fail_cnt capture; otherwise those outputs are constant 0.
// ---------------------------------------------------------------------------
module ra_64x72_bist
    import ra_64x72_bist_pkg::*;
#(
    parameter int                 RD_LAT  = 2,
    parameter logic [BIST_DW-1:0] PATTERN = 72'hAAAA_AAAA_AAAA_AAAA_AA
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [BIST_AW-1:0] fail_adr,
    output logic               fail_port,
    output logic [7:0]         fail_cnt,
    input  logic               sys_rd_enb_0,
    input  logic [BIST_AW-1:0] sys_rd_adr_0,
    input  logic               sys_rd_enb_1,
    input  logic [BIST_AW-1:0] sys_rd_adr_1,
    input  logic               sys_wr_enb_0,
    input  logic [BIST_AW-1:0] sys_wr_adr_0,
    input  logic [BIST_DW-1:0] sys_wr_dat_0,
    output logic               ra_rd_enb_0,
    output logic [BIST_AW-1:0] ra_rd_adr_0,
    output logic               ra_rd_enb_1,
    output logic [BIST_AW-1:0] ra_rd_adr_1,
    output logic               ra_wr_enb_0,
    output logic [BIST_AW-1:0] ra_wr_adr_0,
    output logic [BIST_DW-1:0] ra_wr_dat_0,
    input  logic [BIST_DW-1:0] ra_rd_dat_0,
    input  logic [BIST_DW-1:0] ra_rd_dat_1
);

    localparam logic [BIST_AW-1:0] ADR_LAST = BIST_AW'(BIST_NADR - 1);
    localparam logic [7:0]         GAP_LAST = 8'(BIST_GAP - 1);
    localparam logic [7:0]         DRN_LAST = 8'(RD_LAT - 1);

    bist_state_e        state_q;
    logic [BIST_AW-1:0] adr_q;
    logic [7:0]         wait_q;
    logic               busy_q;
    logic               done_q;
    logic               fail_q;

    logic               start_acc;
    logic               mis_0;
    logic               mis_1;
    logic [BIST_AW-1:0] mis_adr_0;
    logic [BIST_AW-1:0] mis_adr_1;

    // Engine-side port drive; idle ports stay at enable/address/data 0.
    logic               eng_rd_enb_0;
    logic [BIST_AW-1:0] eng_rd_adr_0;
    logic               eng_rd_enb_1;
    logic [BIST_AW-1:0] eng_rd_adr_1;
    logic               eng_wr_enb_0;
    logic [BIST_AW-1:0] eng_wr_adr_0;
    logic [BIST_DW-1:0] eng_wr_dat_0;
    logic [BIST_DW-1:0] eng_exp_0;
    logic [BIST_DW-1:0] eng_exp_1;

    assign start_acc = (state_q == ST_IDLE) && start;

    // ------------------------------------------------------------------
    // March sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_W0;
                        adr_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        fail_q  <= 1'b0;
                    end
                end
                ST_W0: begin
                    if (adr_q == ADR_LAST) begin
                        state_q <= ST_G0;
                        wait_q  <= '0;
                    end else begin
                        adr_q <= adr_q + 1'b1;
                    end
                end
                ST_G0: begin
                    if (wait_q == GAP_LAST) begin
                        state_q <= ST_R0;
                        adr_q   <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_R0: begin
                    if (adr_q == ADR_LAST) begin
                        state_q <= ST_G1;
                        wait_q  <= '0;
                    end else begin
                        adr_q <= adr_q + 1'b1;
                    end
                end
                ST_G1: begin
                    if (wait_q == GAP_LAST) begin
                        state_q <= ST_W1;
                        adr_q   <= ADR_LAST;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_W1: begin
                    if (adr_q == '0) begin
                        state_q <= ST_G2;
                        wait_q  <= '0;
                    end else begin
                        adr_q <= adr_q - 1'b1;
                    end
                end
                ST_G2: begin
                    if (wait_q == GAP_LAST) begin
                        state_q <= ST_R1;
                        adr_q   <= ADR_LAST;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_R1: begin
                    if (adr_q == '0) begin
                        state_q <= ST_DRAIN;
                        wait_q  <= '0;
                    end else begin
                        adr_q <= adr_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (wait_q == DRN_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Compare valids only exist while a run is in flight, and the
            // final compare lands on the last DRAIN edge.
            if (mis_0 || mis_1) begin
                fail_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Engine port drive. Port 1 walks the mirror address 63-a, which for
    // a 6-bit address is simply ~a.
    // ------------------------------------------------------------------
    always_comb begin
        eng_rd_enb_0 = 1'b0;
        eng_rd_adr_0 = '0;
        eng_rd_enb_1 = 1'b0;
        eng_rd_adr_1 = '0;
        eng_wr_enb_0 = 1'b0;
        eng_wr_adr_0 = '0;
        eng_wr_dat_0 = '0;
        eng_exp_0    = '0;
        eng_exp_1    = '0;
        case (state_q)
            ST_W0: begin
                eng_wr_enb_0 = 1'b1;
                eng_wr_adr_0 = adr_q;
                eng_wr_dat_0 = bg_word(adr_q, PATTERN);
            end
            ST_W1: begin
                eng_wr_enb_0 = 1'b1;
                eng_wr_adr_0 = adr_q;
                eng_wr_dat_0 = ~bg_word(adr_q, PATTERN);
            end
            ST_R0, ST_R1: begin
                eng_rd_enb_0 = 1'b1;
                eng_rd_adr_0 = adr_q;
                eng_rd_enb_1 = 1'b1;
                eng_rd_adr_1 = ~adr_q;
                eng_exp_0    = bg_word(adr_q, PATTERN);
                eng_exp_1    = bg_word(~adr_q, PATTERN);
                if (state_q == ST_R1) begin
                    eng_exp_0 = ~eng_exp_0;
                    eng_exp_1 = ~eng_exp_1;
                end
            end
            default: ;
        endcase
    end

    // Port mux: functional requests reach the array only while idle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            ra_rd_enb_0 = sys_rd_enb_0;
            ra_rd_adr_0 = sys_rd_adr_0;
            ra_rd_enb_1 = sys_rd_enb_1;
            ra_rd_adr_1 = sys_rd_adr_1;
            ra_wr_enb_0 = sys_wr_enb_0;
            ra_wr_adr_0 = sys_wr_adr_0;
            ra_wr_dat_0 = sys_wr_dat_0;
        end else begin
            ra_rd_enb_0 = eng_rd_enb_0;
            ra_rd_adr_0 = eng_rd_adr_0;
            ra_rd_enb_1 = eng_rd_enb_1;
            ra_rd_adr_1 = eng_rd_adr_1;
            ra_wr_enb_0 = eng_wr_enb_0;
            ra_wr_adr_0 = eng_wr_adr_0;
            ra_wr_dat_0 = eng_wr_dat_0;
        end
    end

    // ------------------------------------------------------------------
    // Per-port checkers
    // ------------------------------------------------------------------
    ra_bist_cmp #(.RD_LAT(RD_LAT), .DW(BIST_DW), .AW(BIST_AW)) u_cmp_0 (
        .clk       (clk),
        .reset     (reset),
        .iss_vld_i (eng_rd_enb_0),
        .iss_adr_i (eng_rd_adr_0),
        .iss_exp_i (eng_exp_0),
        .rd_dat_i  (ra_rd_dat_0),
        .mis_o     (mis_0),
        .mis_adr_o (mis_adr_0)
    );

    ra_bist_cmp #(.RD_LAT(RD_LAT), .DW(BIST_DW), .AW(BIST_AW)) u_cmp_1 (
        .clk       (clk),
        .reset     (reset),
        .iss_vld_i (eng_rd_enb_1),
        .iss_adr_i (eng_rd_adr_1),
        .iss_exp_i (eng_exp_1),
        .rd_dat_i  (ra_rd_dat_1),
        .mis_o     (mis_1),
        .mis_adr_o (mis_adr_1)
    );

    // ------------------------------------------------------------------
    // Diagnostic capture
    // ------------------------------------------------------------------
`ifdef TOYSRAM_BIST_DIAG_EN
    logic [BIST_AW-1:0] fail_adr_q;
    logic               fail_port_q;
    logic [7:0]         fail_cnt_q;
    logic [8:0]         cnt_sum;

    assign cnt_sum = 9'(fail_cnt_q) + 9'(mis_0) + 9'(mis_1);

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            fail_adr_q  <= '0;
            fail_port_q <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            // First miscompare only; port 0 takes priority on a tie.
            if (!fail_q && (mis_0 || mis_1)) begin
                fail_adr_q  <= mis_0 ? mis_adr_0 : mis_adr_1;
                fail_port_q <= !mis_0;
            end
            fail_cnt_q <= (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
        end
    end

    assign fail_adr  = fail_adr_q;
    assign fail_port = fail_port_q;
    assign fail_cnt  = fail_cnt_q;
`else
    logic diag_unused;
    assign diag_unused = ^{mis_adr_0, mis_adr_1, start_acc};

    assign fail_adr  = '0;
    assign fail_port = 1'b0;
    assign fail_cnt  = '0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign fail = fail_q;

endmodule

// File: tb/tb_ra_64x72_bist.sv
module tb_ra_64x72_bist;

`ifdef TOYSRAM_BIST_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_a, start_b;
    logic        sys_rd_enb_0, sys_rd_enb_1, sys_wr_enb_0;
    logic [5:0]  sys_rd_adr_0, sys_rd_adr_1, sys_wr_adr_0;
    logic [71:0] sys_wr_dat_0;

    // DUT A: RD_LAT=2 with latched array model
    logic        busy_a, done_a, fail_a, fail_port_a;
    logic [5:0]  fail_adr_a;
    logic [7:0]  fail_cnt_a;
    logic        a_rd_enb_0, a_rd_enb_1, a_wr_enb_0;
    logic [5:0]  a_rd_adr_0, a_rd_adr_1, a_wr_adr_0;
    logic [71:0] a_wr_dat_0, a_rd_dat_0, a_rd_dat_1;

    // DUT B: RD_LAT=1 with unlatched array model
    logic        busy_b, done_b, fail_b, fail_port_b;
    logic [5:0]  fail_adr_b;
    logic [7:0]  fail_cnt_b;
    logic        b_rd_enb_0, b_rd_enb_1, b_wr_enb_0;
    logic [5:0]  b_rd_adr_0, b_rd_adr_1, b_wr_adr_0;
    logic [71:0] b_wr_dat_0, b_rd_dat_0, b_rd_dat_1;

    ra_64x72_bist #(.RD_LAT(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .busy(busy_a), .done(done_a), .fail(fail_a),
        .fail_adr(fail_adr_a), .fail_port(fail_port_a), .fail_cnt(fail_cnt_a),
        .sys_rd_enb_0(sys_rd_enb_0), .sys_rd_adr_0(sys_rd_adr_0),
        .sys_rd_enb_1(sys_rd_enb_1), .sys_rd_adr_1(sys_rd_adr_1),
        .sys_wr_enb_0(sys_wr_enb_0), .sys_wr_adr_0(sys_wr_adr_0), .sys_wr_dat_0(sys_wr_dat_0),
        .ra_rd_enb_0(a_rd_enb_0), .ra_rd_adr_0(a_rd_adr_0),
        .ra_rd_enb_1(a_rd_enb_1), .ra_rd_adr_1(a_rd_adr_1),
        .ra_wr_enb_0(a_wr_enb_0), .ra_wr_adr_0(a_wr_adr_0), .ra_wr_dat_0(a_wr_dat_0),
        .ra_rd_dat_0(a_rd_dat_0), .ra_rd_dat_1(a_rd_dat_1)
    );

    ra_64x72_bist #(.RD_LAT(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .busy(busy_b), .done(done_b), .fail(fail_b),
        .fail_adr(fail_adr_b), .fail_port(fail_port_b), .fail_cnt(fail_cnt_b),
        .sys_rd_enb_0(sys_rd_enb_0), .sys_rd_adr_0(sys_rd_adr_0),
        .sys_rd_enb_1(sys_rd_enb_1), .sys_rd_adr_1(sys_rd_adr_1),
        .sys_wr_enb_0(sys_wr_enb_0), .sys_wr_adr_0(sys_wr_adr_0), .sys_wr_dat_0(sys_wr_dat_0),
        .ra_rd_enb_0(b_rd_enb_0), .ra_rd_adr_0(b_rd_adr_0),
        .ra_rd_enb_1(b_rd_enb_1), .ra_rd_adr_1(b_rd_adr_1),
        .ra_wr_enb_0(b_wr_enb_0), .ra_wr_adr_0(b_wr_adr_0), .ra_wr_dat_0(b_wr_dat_0),
        .ra_rd_dat_0(b_rd_dat_0), .ra_rd_dat_1(b_rd_dat_1)
    );

    // Fault injection applied on the read path of both array models
    bit          flt_en, flt_all;
    logic [5:0]  flt_adr0, flt_adr1;
    logic [71:0] flt_or, flt_xor;

    function automatic logic [71:0] arr_rd(input logic [5:0] adr, input logic [71:0] v);
        if (flt_en && (flt_all || adr == flt_adr0 || adr == flt_adr1))
            return (v | flt_or) ^ flt_xor;
        return v;
    endfunction

    logic [71:0] mem_a [64];
    logic [71:0] s1_a0, s1_a1;
    always @(posedge clk) begin
        if (a_wr_enb_0) mem_a[a_wr_adr_0] <= a_wr_dat_0;
        if (a_rd_enb_0) s1_a0 <= arr_rd(a_rd_adr_0, mem_a[a_rd_adr_0]);
        if (a_rd_enb_1) s1_a1 <= arr_rd(a_rd_adr_1, mem_a[a_rd_adr_1]);
        a_rd_dat_0 <= s1_a0;
        a_rd_dat_1 <= s1_a1;
    end

    logic [71:0] mem_b [64];
    always @(posedge clk) begin
        if (b_wr_enb_0) mem_b[b_wr_adr_0] <= b_wr_dat_0;
        if (b_rd_enb_0) b_rd_dat_0 <= arr_rd(b_rd_adr_0, mem_b[b_rd_adr_0]);
        if (b_rd_enb_1) b_rd_dat_1 <= arr_rd(b_rd_adr_1, mem_b[b_rd_adr_1]);
    end

    // Observation mux for the run task
    bit          sel;
    logic        o_busy, o_done, o_fail, o_port, o_rd_enb0, o_rd_enb1, o_wr_enb;
    logic [5:0]  o_adr;
    logic [7:0]  o_cnt;
    always_comb begin
        o_busy    = sel ? busy_b      : busy_a;
        o_done    = sel ? done_b      : done_a;
        o_fail    = sel ? fail_b      : fail_a;
        o_port    = sel ? fail_port_b : fail_port_a;
        o_adr     = sel ? fail_adr_b  : fail_adr_a;
        o_cnt     = sel ? fail_cnt_b  : fail_cnt_a;
        o_rd_enb0 = sel ? b_rd_enb_0  : a_rd_enb_0;
        o_rd_enb1 = sel ? b_rd_enb_1  : a_rd_enb_1;
        o_wr_enb  = sel ? b_wr_enb_0  : a_wr_enb_0;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         done_cyc;
        logic       fail;
        logic [5:0] adr;
        logic       port;
        logic [7:0] cnt;
    } run_exp_t;

    run_exp_t    sbq[$];
    logic [71:0] rdq[$];

    function automatic run_exp_t mk(input int dc, input logic f, input logic [5:0] adr,
                                    input logic port, input logic [7:0] cnt);
        run_exp_t e;
        e.done_cyc = dc;
        e.fail     = f;
        e.adr      = DIAG ? adr  : 6'd0;
        e.port     = DIAG ? port : 1'b0;
        e.cnt      = DIAG ? cnt  : 8'd0;
        return e;
    endfunction

    // One run: start sampled at edge 0, cycle k observed at the negedge
    // after edge k-1.
    task automatic do_run(input string name, input bit s, input int pulse_at);
        run_exp_t e;
        int cyc;
        sel = s;
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 1;
        chk({name, "_busy_c1"}, o_busy, 1);
        chk({name, "_done_c1"}, o_done, 0);
        while (!o_done && cyc < 400) begin
            if (cyc == 65) chk({name, "_gap_enb"}, {o_rd_enb0, o_rd_enb1, o_wr_enb}, 0);
            start_a = (cyc == pulse_at) && !s;
            start_b = (cyc == pulse_at) && s;
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        e = sbq.pop_front();
        chk({name, "_done_cyc"}, cyc, e.done_cyc);
        chk({name, "_busy_end"}, o_busy, 0);
        chk({name, "_fail"}, o_fail, e.fail);
        chk({name, "_fail_adr"}, o_adr, e.adr);
        chk({name, "_fail_port"}, o_port, e.port);
        chk({name, "_fail_cnt"}, o_cnt, e.cnt);
        @(negedge clk);
        chk({name, "_done_hold"}, o_done, 1);
        $display("run %s: done_cyc=%0d fail=%0b adr=%0d port=%0b cnt=%0d",
                 name, cyc, o_fail, o_adr, o_port, o_cnt);
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        sys_rd_enb_0 = 0; sys_rd_enb_1 = 0; sys_wr_enb_0 = 0;
        sys_rd_adr_0 = 0; sys_rd_adr_1 = 0; sys_wr_adr_0 = 0; sys_wr_dat_0 = '0;
        flt_en = 0; flt_all = 0; flt_adr0 = 0; flt_adr1 = 0; flt_or = '0; flt_xor = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_fail_adr", fail_adr_a, 0);
        chk("rst_fail_port", fail_port_a, 0);
        chk("rst_fail_cnt", fail_cnt_a, 0);
        reset = 1'b0;

        // Idle passthrough: write then read back on port 1
        @(negedge clk);
        sys_wr_enb_0 = 1; sys_wr_adr_0 = 6'd7; sys_wr_dat_0 = 72'h123;
        #1;
        chk("pt_wr_enb", a_wr_enb_0, 1);
        chk("pt_wr_adr", a_wr_adr_0, 7);
        chk("pt_wr_dat", a_wr_dat_0, 72'h123);
        @(negedge clk);
        sys_wr_enb_0 = 0; sys_rd_enb_1 = 1; sys_rd_adr_1 = 6'd7;
        rdq.push_back(72'h123);
        @(negedge clk);
        sys_rd_enb_1 = 0;
        @(negedge clk);
        chk("pt_rd1", a_rd_dat_1, rdq.pop_front());
        $display("passthrough: rd_dat_1=%0h", a_rd_dat_1);

        // Fault-free with functional writes held active and a stray start
        sys_wr_enb_0 = 1; sys_wr_adr_0 = 6'd5; sys_wr_dat_0 = '0;
        sys_rd_enb_0 = 1; sys_rd_adr_0 = 6'd3;
        sbq.push_back(mk(262, 0, 0, 0, 0));
        do_run("clean", 0, 100);
        sys_wr_enb_0 = 0; sys_rd_enb_0 = 0;

        // Stuck-at-1 on bit 4 at address 10: hits in R0, port 0 first
        flt_en = 1; flt_adr0 = 6'd10; flt_adr1 = 6'd10; flt_or = 72'h10; flt_xor = '0;
        sbq.push_back(mk(262, 1, 10, 0, 2));
        do_run("sa1_b4", 0, 0);

        // Stuck-at-1 on bit 5 at address 10: hits in R1, port 1 (a=53) first
        flt_or = 72'h20;
        sbq.push_back(mk(262, 1, 10, 1, 2));
        do_run("sa1_b5", 0, 0);

        // Bit flips at 10 and 53: both ports miss in one cycle, port 0 wins
        flt_or = '0; flt_xor = 72'h1; flt_adr1 = 6'd53;
        sbq.push_back(mk(262, 1, 10, 0, 8));
        do_run("tie", 0, 0);

        // Every read wrong: 256 misses saturate the count
        flt_all = 1;
        sbq.push_back(mk(262, 1, 0, 0, 255));
        do_run("sat", 0, 0);
        flt_all = 0; flt_en = 0; flt_xor = '0;

        // Reset in the middle of a run
        sel = 0;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (149) @(negedge clk);
        reset = 1;
        sys_rd_enb_0 = 1; sys_rd_adr_0 = 6'h2A;
        @(negedge clk);
        reset = 0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_rd_enb", a_rd_enb_0, 1);
        chk("abort_rd_adr", a_rd_adr_0, 6'h2A);
        chk("abort_wr_enb", a_wr_enb_0, 0);
        $display("abort: busy=%0b done=%0b rd_adr_0=%0h", busy_a, done_a, a_rd_adr_0);
        sys_rd_enb_0 = 0; sys_rd_adr_0 = 0;
        sbq.push_back(mk(262, 0, 0, 0, 0));
        do_run("after_rst", 0, 0);

        // RD_LAT=1 instance
        sbq.push_back(mk(261, 0, 0, 0, 0));
        do_run("lat1", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
